fifo_ptr_ctrl: RTL and testbench

Single-clock FIFO pointer and flag controller. It sequences the read and write pointers of a 2**ADDR_LEN-entry dual-port RAM. It accepts write and read requests and gates them into RAM enables and addresses. It produces full, empty, almost-full, almost-empty, occupancy count and sticky error flags. Pointers are also exported in gray code so the same block can later feed a CDC synchronizer unchanged.

---
 rtl/fifo_ctrl_pkg.sv | 37 +++
 rtl/fifo_ptr_ctrl_gray_ptr.sv | 49 ++++
 rtl/fifo_ptr_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared types and helpers for the FIFO pointer controller.
//   bin2gray  : binary to reflected gray conversion
//   ptr_empty : gray pointers equal -> FIFO empty
//   ptr_full  : gray pointers differ only in their top two bits -> FIFO full
// Helpers operate on pointers zero-extended to the widest legal width
// (ADDR_LEN up to 12), so one set of functions serves every ADDR_LEN.
package fifo_ctrl_pkg;

    localparam int ADDR_LEN_MAX     = 12;
    localparam int MAX_PTR_W        = ADDR_LEN_MAX + 1;
    localparam int ADDR_LEN_DEFAULT = 4;
    localparam int PTR_W            = ADDR_LEN_DEFAULT + 1;

    typedef logic [PTR_W-1:0]     ptr_t;
    typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

    function automatic wide_ptr_t bin2gray(input wide_ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic ptr_empty(input wide_ptr_t wr_gray,
                                       input wide_ptr_t rd_gray);
        return wr_gray == rd_gray;
    endfunction

    // In gray code a pointer exactly one lap ahead differs in the wrap bit
    // and the bit just below it; all lower bits match.
    function automatic logic ptr_full(input wide_ptr_t wr_gray,
                                      input wide_ptr_t rd_gray,
                                      input int        addr_len);
        wide_ptr_t mask;
        mask = wide_ptr_t'(3) << (addr_len - 1);
        return wr_gray == (rd_gray ^ mask);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_gray_ptr.sv
// gray_ptr
// One FIFO pointer: binary counter with wrap bit plus a registered gray copy.
// Ports:
//   clk, reset, clear : clock, synchronous active-high reset and flush
//   inc               : advance the pointer at the next edge
//   bin, gray         : registered pointer in binary and gray code
//   bin_next,gray_next: combinational next-state values for flag logic
module gray_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_LEN:0] bin,
    output logic [ADDR_LEN:0] gray,
    output logic [ADDR_LEN:0] bin_next,
    output logic [ADDR_LEN:0] gray_next
);

    localparam int PW = ADDR_LEN + 1;

    wide_ptr_t gray_wide;

    assign bin_next  = bin + {{ADDR_LEN{1'b0}}, inc};
    assign gray_wide = bin2gray(MAX_PTR_W'(bin_next));
    assign gray_next = gray_wide[PW-1:0];

    // Bits above the pointer width are always zero after conversion.
    generate
        if (PW < MAX_PTR_W) begin : g_hi
            logic unused_gray_hi;
            assign unused_gray_hi = |gray_wide[MAX_PTR_W-1:PW];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_next;
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
// Single-clock FIFO pointer/flag controller for a 2**ADDR_LEN entry RAM.
// Ports:
//   clk, reset, clear      : clock, synchronous reset, synchronous flush
//   wr_req, rd_req         : producer / consumer requests
//   wr_en, wr_addr         : accepted write and its RAM address
//   rd_en, rd_addr         : accepted read and its RAM address
//   full, empty            : registered occupancy flags
//   almost_full/_empty     : threshold flags on count
//   count                  : occupancy 0..2**ADDR_LEN
//   wr_ptr_gray/rd_ptr_gray: gray-coded pointers for a future CDC path
//   overflow, underflow    : sticky request-while-blocked errors
module fifo_ptr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_LEN      = 4,
    parameter int AFULL_THRESH  = 2**ADDR_LEN - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                wr_req,
    input  logic                rd_req,
    output logic                wr_en,
    output logic [ADDR_LEN-1:0] wr_addr,
    output logic                rd_en,
    output logic [ADDR_LEN-1:0] rd_addr,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_LEN:0]   count,
    output logic [ADDR_LEN:0]   wr_ptr_gray,
    output logic [ADDR_LEN:0]   rd_ptr_gray,
    output logic                overflow,
    output logic                underflow
);

    localparam int PW = ADDR_LEN + 1;

    logic [PW-1:0] wr_bin, rd_bin;
    logic [PW-1:0] wr_bin_next, rd_bin_next;
    logic [PW-1:0] wr_gray_next, rd_gray_next;
    logic [PW-1:0] count_next;

    assign wr_en   = wr_req & ~full;
    assign rd_en   = rd_req & ~empty;
    assign wr_addr = wr_bin[ADDR_LEN-1:0];
    assign rd_addr = rd_bin[ADDR_LEN-1:0];

    // The wrap bits only matter through the next-state pointers.
    logic unused_wrap_bits;
    assign unused_wrap_bits = wr_bin[ADDR_LEN] ^ rd_bin[ADDR_LEN];

    gray_ptr #(.ADDR_LEN(ADDR_LEN)) u_wr_ptr (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inc       (wr_en),
        .bin       (wr_bin),
        .gray      (wr_ptr_gray),
        .bin_next  (wr_bin_next),
        .gray_next (wr_gray_next)
    );

    gray_ptr #(.ADDR_LEN(ADDR_LEN)) u_rd_ptr (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inc       (rd_en),
        .bin       (rd_bin),
        .gray      (rd_ptr_gray),
        .bin_next  (rd_bin_next),
        .gray_next (rd_gray_next)
    );

    // Modular subtraction gives the right occupancy across pointer wrap.
    assign count_next = wr_bin_next - rd_bin_next;

    // Flags are derived from next-state pointers so they line up with the
    // pointer registers; errors latch until reset or clear.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_next;
            empty        <= ptr_empty(MAX_PTR_W'(wr_gray_next),
                                      MAX_PTR_W'(rd_gray_next));
            full         <= ptr_full(MAX_PTR_W'(wr_gray_next),
                                     MAX_PTR_W'(rd_gray_next), ADDR_LEN);
            almost_full  <= (count_next >= PW'(AFULL_THRESH));
            almost_empty <= (count_next <= PW'(AEMPTY_THRESH));
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            if (rd_req && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl
// Directed bench for fifo_ptr_ctrl at ADDR_LEN=4 (16 entries, 5-bit pointers).
// Inputs change on the falling edge; outputs are sampled 1 ns later, so the
// combinational enables reflect the current request and the registered flags
// reflect everything committed at earlier rising edges.
module tb_fifo_ptr_ctrl;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       wr_req;
    logic       rd_req;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic [4:0] wr_ptr_gray;
    logic [4:0] rd_ptr_gray;
    logic       overflow;
    logic       underflow;

    int checksDone;
    int checksPassed;

    fifo_ptr_ctrl #(.ADDR_LEN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_ptr_gray  (wr_ptr_gray),
        .rd_ptr_gray  (rd_ptr_gray),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic w, input logic r,
                                 input logic c, input logic rst);
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        clear  = c;
        reset  = rst;
        #1;
    endtask

    task automatic checkOutput(input string tag, input int got, input int exp);
        checksDone++;
        if (got == exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int grayOf(input int n);
        int m;
        m = n % 32;
        return m ^ (m >> 1);
    endfunction

    task automatic checkIdleEmpty(input string tag);
        checkOutput({tag, " count"}, 32'(count), 0);
        checkOutput({tag, " empty"}, 32'(empty), 1);
        checkOutput({tag, " full"}, 32'(full), 0);
        checkOutput({tag, " almost_empty"}, 32'(almost_empty), 1);
        checkOutput({tag, " almost_full"}, 32'(almost_full), 0);
        checkOutput({tag, " overflow"}, 32'(overflow), 0);
        checkOutput({tag, " underflow"}, 32'(underflow), 0);
        checkOutput({tag, " wr_ptr_gray"}, 32'(wr_ptr_gray), 0);
        checkOutput({tag, " rd_ptr_gray"}, 32'(rd_ptr_gray), 0);
        checkOutput({tag, " wr_addr"}, 32'(wr_addr), 0);
        checkOutput({tag, " rd_addr"}, 32'(rd_addr), 0);
    endtask

    initial begin
        logic [4:0] prevWrGray;
        logic [4:0] prevRdGray;
        checksDone   = 0;
        checksPassed = 0;
        reset  = 1'b1;
        clear  = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Reset state
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkIdleEmpty("reset");

        // Fill 16 entries
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput($sformatf("fill%0d wr_en", i), 32'(wr_en), 1);
            checkOutput($sformatf("fill%0d wr_addr", i), 32'(wr_addr), i);
            checkOutput($sformatf("fill%0d count", i), 32'(count), i);
            checkOutput($sformatf("fill%0d almost_full", i), 32'(almost_full),
                        (i >= 14) ? 1 : 0);
            checkOutput($sformatf("fill%0d almost_empty", i), 32'(almost_empty),
                        (i <= 2) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("filled full", 32'(full), 1);
        checkOutput("filled empty", 32'(empty), 0);
        checkOutput("filled count", 32'(count), 16);
        checkOutput("filled wr_ptr_gray", 32'(wr_ptr_gray), 32'b11000);
        checkOutput("filled almost_full", 32'(almost_full), 1);

        // Write while full
        applyStimulus(1, 0, 0, 0);
        checkOutput("ovf wr_en", 32'(wr_en), 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("ovf sticky", 32'(overflow), 1);
        checkOutput("ovf wr_addr", 32'(wr_addr), 0);
        checkOutput("ovf wr_ptr_gray", 32'(wr_ptr_gray), 32'b11000);
        checkOutput("ovf count", 32'(count), 16);
        checkOutput("ovf underflow", 32'(underflow), 0);

        // Simultaneous requests while full
        applyStimulus(1, 1, 0, 0);
        checkOutput("fullrw rd_en", 32'(rd_en), 1);
        checkOutput("fullrw wr_en", 32'(wr_en), 0);
        checkOutput("fullrw rd_addr", 32'(rd_addr), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("fullrw count", 32'(count), 15);
        checkOutput("fullrw full", 32'(full), 0);
        checkOutput("fullrw overflow", 32'(overflow), 1);
        checkOutput("fullrw rd_ptr_gray", 32'(rd_ptr_gray), 1);
        checkOutput("fullrw rd_addr", 32'(rd_addr), 1);

        // Simultaneous requests while empty
        applyStimulus(0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("emptyrw wr_en", 32'(wr_en), 1);
        checkOutput("emptyrw rd_en", 32'(rd_en), 0);
        checkOutput("emptyrw overflow", 32'(overflow), 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("emptyrw underflow", 32'(underflow), 1);
        checkOutput("emptyrw count", 32'(count), 1);
        checkOutput("emptyrw empty", 32'(empty), 0);
        checkOutput("emptyrw rd_addr", 32'(rd_addr), 0);

        // 40 write/read pairs: both pointers wrap past 31
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0);
        prevWrGray = wr_ptr_gray;
        prevRdGray = rd_ptr_gray;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput($sformatf("pair%0d wr_en", k), 32'(wr_en), 1);
            checkOutput($sformatf("pair%0d wr_addr", k), 32'(wr_addr), k % 16);
            checkOutput($sformatf("pair%0d count0", k), 32'(count), 0);
            checkOutput($sformatf("pair%0d rd_gray", k), 32'(rd_ptr_gray), grayOf(k));
            if (k > 0) begin
                checkOutput($sformatf("pair%0d rd_hamming", k),
                            $countones(32'(prevRdGray ^ rd_ptr_gray)), 1);
            end
            prevRdGray = rd_ptr_gray;
            applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("pair%0d rd_en", k), 32'(rd_en), 1);
            checkOutput($sformatf("pair%0d rd_addr", k), 32'(rd_addr), k % 16);
            checkOutput($sformatf("pair%0d count1", k), 32'(count), 1);
            checkOutput($sformatf("pair%0d wr_gray", k), 32'(wr_ptr_gray), grayOf(k + 1));
            checkOutput($sformatf("pair%0d wr_hamming", k),
                        $countones(32'(prevWrGray ^ wr_ptr_gray)), 1);
            prevWrGray = wr_ptr_gray;
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("pairs rd_gray", 32'(rd_ptr_gray), grayOf(40));
        checkOutput("pairs rd_hamming", $countones(32'(prevRdGray ^ rd_ptr_gray)), 1);
        checkOutput("pairs empty", 32'(empty), 1);
        checkOutput("pairs underflow", 32'(underflow), 0);
        checkOutput("pairs overflow", 32'(overflow), 0);

        // Clear together with a write at count 7, after provoking underflow
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0);
        end
        applyStimulus(1, 0, 1, 0);
        checkOutput("clear pre count", 32'(count), 7);
        checkOutput("clear pre underflow", 32'(underflow), 1);
        applyStimulus(0, 1, 0, 0);
        checkOutput("clear wr_en", 32'(wr_en), 0);
        checkOutput("clear rd_en", 32'(rd_en), 0);
        checkIdleEmpty("clear");

        // Reset mid-operation with both requests active
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0);
        end
        applyStimulus(1, 1, 0, 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rstmid wr_en", 32'(wr_en), 0);
        checkOutput("rstmid rd_en", 32'(rd_en), 0);
        checkIdleEmpty("rstmid");

        $display("[TB] %0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
